// File: rtl/gray_seq_source.sv
`default_nettype none
// ============================================================================
// Module   : gray_seq_source
// Purpose  : Up/down binary counter presented as a registered Gray word plus
//            its binary mirror over a valid/ready handshake. Optional
//            one-bit-step checker enabled by defining GRAY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_seq_source #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             wrap,
   output logic             gray_err
);

   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_max  = '1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             fire;

   // Next-state: load overrides everything, otherwise advance only on a fire
   always_comb begin
      fire    = valid_q & out_ready;
      state_d = state_q;
      bin_d   = bin_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      if (load) begin
         // A word consumed in this same cycle is discarded, not advanced
         bin_d   = load_val;
         valid_d = 1'b1;
         state_d = ST_ACTIVE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_d = ST_ACTIVE;
                  valid_d = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (fire) begin
                  bin_d   = up_dn ? (bin_q + c_one) : (bin_q - c_one);
                  wrap_d  = up_dn ? (bin_q == c_max) : (bin_q == c_zero);
                  valid_d = en;
                  state_d = en ? ST_ACTIVE : ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
      // Gray word is derived from the next count so both register together
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         gray_q  <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign gray_out  = gray_q;
   assign bin_out   = bin_q;
   assign out_valid = valid_q;
   assign wrap      = wrap_q;

`ifdef GRAY_CHECK_EN
   logic [WIDTH-1:0] last_gray_q, last_gray_d;
   logic             have_last_q, have_last_d;
   logic             gray_err_q, gray_err_d;

   // Compare each fired word with the previously fired one; any step other
   // than exactly one bit sets a sticky error
   always_comb begin
      last_gray_d = last_gray_q;
      have_last_d = have_last_q;
      gray_err_d  = gray_err_q;
      if (load) begin
         last_gray_d = '0;
         have_last_d = 1'b0;
      end else if (fire) begin
         if (have_last_q && ($countones(gray_q ^ last_gray_q) != 1)) begin
            gray_err_d = 1'b1;
         end
         last_gray_d = gray_q;
         have_last_d = 1'b1;
      end
   end

   // Checker registers; the error flag is cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gray_q <= '0;
         have_last_q <= 1'b0;
         gray_err_q  <= 1'b0;
      end else begin
         last_gray_q <= last_gray_d;
         have_last_q <= have_last_d;
         gray_err_q  <= gray_err_d;
      end
   end

   assign gray_err = gray_err_q;
`else
   assign gray_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_seq_source
// Purpose  : Self-checking bench for gray_seq_source (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_seq_source;

   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             up_dn = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] gray_out;
   logic [WIDTH-1:0] bin_out;
   logic             out_valid;
   logic             wrap;
   logic             gray_err;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_cnt  = 0;
   bit m_valid = 1'b0;
   bit m_wrap  = 1'b0;
   bit m_have  = 1'b0;
   int m_last  = 0;
   bit m_err   = 1'b0;

   gray_seq_source #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up_dn     (up_dn),
      .load      (load),
      .load_val  (load_val),
      .gray_out  (gray_out),
      .bin_out   (bin_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wrap      (wrap),
      .gray_err  (gray_err)
   );

   always #5 clk = ~clk;

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int popcount(input int v);
      int n = 0;
      for (int k = 0; k < 32; k++) n += (v >> k) & 1;
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ev, input int eb, input int eg, input int ew);
      chk({tag, ".valid"}, int'(out_valid), ev);
      chk({tag, ".bin"},   int'(bin_out),   eb);
      chk({tag, ".gray"},  int'(gray_out),  eg);
      chk({tag, ".wrap"},  int'(wrap),      ew);
      chk({tag, ".err"},   int'(gray_err),  0);
   endtask

   // Apply one cycle of inputs, clock, and advance the reference model
   task automatic tick(input bit r, input bit e, input bit u, input bit l, input int lv, input bit rd);
      rst = r; en = e; up_dn = u; load = l; out_ready = rd;
      load_val = WIDTH'(lv);
      @(posedge clk);
      #1;
      if (r) begin
         m_valid = 0; m_cnt = 0; m_wrap = 0; m_have = 0; m_last = 0; m_err = 0;
      end else if (l) begin
         m_cnt = lv % MOD; m_valid = 1; m_wrap = 0; m_have = 0; m_last = 0;
      end else if (!m_valid) begin
         m_wrap = 0;
         if (e) m_valid = 1;
      end else if (rd) begin
         if (m_have && popcount(gray_of(m_cnt) ^ m_last) != 1) m_err = 1;
         m_last  = gray_of(m_cnt);
         m_have  = 1;
         m_wrap  = u ? (m_cnt == MOD - 1) : (m_cnt == 0);
         m_cnt   = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
         m_valid = e;
      end else begin
         m_wrap = 0;
      end
   endtask

   typedef struct {
      bit r, e, u, l;
      int lv;
      bit rd;
      int ev, eb, eg, ew;
   } vec_t;

   vec_t tbl[28];
   int   glist[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

   initial begin
      // ---- vector table: count-up sequence, wrap, stall and release ----
      tbl[0] = '{r:1, e:0, u:0, l:0, lv:0, rd:0, ev:0, eb:0, eg:0, ew:0};
      for (int i = 1; i <= 17; i++)
         tbl[i] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:(i - 1) % 16, eg:glist[i-1], ew:(i == 17) ? 1 : 0};
      tbl[18] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:1, eg:1, ew:0};
      tbl[19] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:2, eg:3, ew:0};
      tbl[20] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:3, eg:2, ew:0};
      tbl[21] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:4, eg:6, ew:0};
      for (int i = 22; i <= 26; i++)
         tbl[i] = '{r:0, e:1, u:(i % 2 == 0) ? 1 : 0, l:0, lv:0, rd:0, ev:1, eb:4, eg:6, ew:0};
      tbl[27] = '{r:0, e:1, u:1, l:0, lv:0, rd:1, ev:1, eb:5, eg:7, ew:0};

      for (int i = 0; i < 28; i++) begin
         tick(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv, tbl[i].rd);
         chk_all($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].eg, tbl[i].ew);
      end

      // ---- load while stalled, then count down; load together with a fire ----
      tick(1, 0, 0, 0, 0, 0);  chk_all("ld.rst", 0, 0, 0, 0);
      tick(0, 1, 1, 0, 0, 1);  chk_all("ld.first", 1, 0, 0, 0);
      tick(0, 1, 1, 0, 0, 1);  chk_all("ld.b1", 1, 1, 1, 0);
      tick(0, 1, 1, 0, 0, 1);  chk_all("ld.b2", 1, 2, 3, 0);
      tick(0, 1, 1, 0, 0, 1);  chk_all("ld.b3", 1, 3, 2, 0);
      tick(0, 1, 1, 0, 0, 0);  chk_all("ld.stall", 1, 3, 2, 0);
      tick(0, 1, 1, 1, 5, 0);  chk_all("ld.load5", 1, 5, 7, 0);
      tick(0, 1, 0, 0, 0, 1);  chk_all("ld.dn4", 1, 4, 6, 0);
      tick(0, 1, 0, 0, 0, 1);  chk_all("ld.dn3", 1, 3, 2, 0);
      tick(0, 1, 0, 1, 9, 1);  chk_all("ld.fire9", 1, 9, 13, 0);
      tick(0, 1, 0, 0, 0, 1);  chk_all("ld.dn8", 1, 8, 12, 0);

      // ---- downward wrap from 0, then mid-stream reset ----
      tick(0, 0, 0, 1, 0, 0);  chk_all("dw.load0", 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 1);  chk_all("dw.wrapF", 1, 15, 8, 1);
      tick(0, 1, 0, 0, 0, 1);  chk_all("dw.E", 1, 14, 9, 0);
      tick(1, 1, 0, 0, 0, 1);  chk_all("dw.rst", 0, 0, 0, 0);

      // ---- en dropped at a fire, idle hold, resume ----
      tick(0, 1, 1, 0, 0, 1);  chk_all("en.first", 1, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick(0, 1, 1, 0, 0, 1);
         chk_all($sformatf("en.b%0d", i), 1, i, gray_of(i), 0);
      end
      tick(0, 0, 1, 0, 0, 1);  chk_all("en.drop", 0, 4, 6, 0);
      tick(0, 0, 0, 0, 0, 1);  chk_all("en.idle", 0, 4, 6, 0);
      tick(0, 1, 0, 0, 0, 0);  chk_all("en.resume", 1, 4, 6, 0);

      // ---- randomized run against the reference model ----
      tick(1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 4000; n++) begin
         tick(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 7) != 0),
              $urandom_range(0, 1),
              ($urandom_range(0, 15) == 0),
              $urandom_range(0, MOD - 1),
              ($urandom_range(0, 3) != 0));
         chk("rnd.valid", int'(out_valid), int'(m_valid));
         chk("rnd.bin",   int'(bin_out),   m_cnt);
         chk("rnd.gray",  int'(gray_out),  gray_of(m_cnt));
         chk("rnd.wrap",  int'(wrap),      int'(m_wrap));
`ifdef GRAY_CHECK_EN
         chk("rnd.err",   int'(gray_err),  int'(m_err));
`else
         chk("rnd.err",   int'(gray_err),  0);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
